// File: rtl/prirv32_lsu.sv
// Load/store and writeback stage: ALU results are written straight back, loads and
// stores run one outstanding req/gnt/rvalid transaction on the data bus.
module prirv32_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        exu_valid_i,
  output logic        exu_ready_o,
  input  logic [3:0]  exu_op_i,
  input  logic [31:0] exu_addr_i,
  input  logic [31:0] exu_wdata_i,
  input  logic [4:0]  exu_rd_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        exc_valid_o,
  output logic [1:0]  exc_cause_o,
  output logic [31:0] exc_addr_o,
  output logic        busy_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES < 1) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] OP_ALU = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_WB} state_e;

  state_e            state_q;
  logic [3:0]        op_q;
  logic [31:0]       addr_q;
  logic [4:0]        rd_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              mem_req_q;
  logic              mem_we_q;
  logic [31:0]       mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;
  logic              reg_we_q;
  logic [4:0]        reg_waddr_q;
  logic [31:0]       reg_wdata_q;
  logic              exc_valid_q;
  logic [1:0]        exc_cause_q;
  logic [31:0]       exc_addr_q;

  logic              accept;
  logic              is_alu;
  logic              is_load;
  logic              is_store;
  logic              is_half;
  logic              is_word;
  logic              misaligned;
  logic              timeout_hit;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d;

  // Pick the addressed lane out of the bus word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [3:0]  op,
                                               input logic [1:0]  lane,
                                               input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {lane, 3'b000};
    case (op)
      OP_LB:   res = {{24{sh[7]}}, sh[7:0]};
      OP_LBU:  res = {24'd0, sh[7:0]};
      OP_LH:   res = {{16{sh[15]}}, sh[15:0]};
      OP_LHU:  res = {16'd0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  assign accept      = exu_valid_i && exu_ready_o;
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

  always_comb begin
    is_alu   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (exu_op_i)
      OP_ALU:        is_alu = 1'b1;
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
      OP_LW:         begin is_load = 1'b1; is_word = 1'b1; end
      OP_SB:         is_store = 1'b1;
      OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
      default:       ;
    endcase
    misaligned = (is_half && exu_addr_i[0]) ||
                 (is_word && (exu_addr_i[1:0] != 2'b00));

    // Store data is replicated across lanes so the byte enables alone select it.
    be_d    = 4'b1111;
    wdata_d = '0;
    if (is_store) begin
      if (is_word) begin
        wdata_d = exu_wdata_i;
      end else if (is_half) begin
        be_d    = exu_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{exu_wdata_i[15:0]}};
      end else begin
        be_d    = 4'b0001 << exu_addr_i[1:0];
        wdata_d = {4{exu_wdata_i[7:0]}};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_addr_q  <= '0;
    end else begin
      reg_we_q    <= 1'b0;
      exc_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q   <= exu_op_i;
            addr_q <= exu_addr_i;
            rd_q   <= exu_rd_i;
            if (is_alu) begin
              reg_we_q    <= (exu_rd_i != 5'd0);
              reg_waddr_q <= exu_rd_i;
              reg_wdata_q <= exu_addr_i;
            end else if ((is_load || is_store) && misaligned) begin
              exc_valid_q <= 1'b1;
              exc_cause_q <= {1'b0, is_store};
              exc_addr_q  <= exu_addr_i;
            end else if (is_load || is_store) begin
              state_q     <= S_REQ;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {exu_addr_i[31:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
            end
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (timeout_hit) begin
            mem_req_q   <= 1'b0;
            state_q     <= S_IDLE;
            exc_valid_q <= 1'b1;
            exc_cause_q <= {1'b1, op_q[3]};
            exc_addr_q  <= addr_q;
          end else if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= S_RESP;
          end
        end
        S_RESP: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // A response arriving in the timeout cycle still completes normally.
          if (mem_rvalid_i) begin
            if (mem_err_i) begin
              state_q     <= S_IDLE;
              exc_valid_q <= 1'b1;
              exc_cause_q <= {1'b1, op_q[3]};
              exc_addr_q  <= addr_q;
            end else if (op_q[3]) begin
              state_q <= S_IDLE;
            end else begin
              reg_we_q    <= (rd_q != 5'd0);
              reg_waddr_q <= rd_q;
              reg_wdata_q <= load_extract(op_q, addr_q[1:0], mem_rdata_i);
              state_q     <= S_WB;
            end
          end else if (timeout_hit) begin
            state_q     <= S_IDLE;
            exc_valid_q <= 1'b1;
            exc_cause_q <= {1'b1, op_q[3]};
            exc_addr_q  <= addr_q;
          end
        end
        S_WB: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign exu_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign reg_we_o    = reg_we_q;
  assign reg_waddr_o = reg_waddr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign exc_valid_o = exc_valid_q;
  assign exc_cause_o = exc_cause_q;
  assign exc_addr_o  = exc_addr_q;

endmodule

// File: tb/tb_prirv32_lsu.sv
// Scoreboard bench for prirv32_lsu: directed ops push expectations, a monitor checks outputs.
module tb_prirv32_lsu;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  // main instance (default timeout)
  logic        exu_valid_i = 0, exu_ready_o;
  logic [3:0]  exu_op_i = 0;
  logic [31:0] exu_addr_i = 0, exu_wdata_i = 0;
  logic [4:0]  exu_rd_i = 0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 0, mem_rvalid_i = 0, mem_err_i = 0;
  logic [31:0] mem_rdata_i = 0;
  logic        reg_we_o, exc_valid_o, busy_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o, exc_addr_o;
  logic [1:0]  exc_cause_o;

  // timeout instance (TIMEOUT_CYCLES=4)
  logic        t_valid_i = 0, t_ready_o;
  logic [3:0]  t_op_i = 0;
  logic [31:0] t_addr_i = 0, t_wdata_i = 0;
  logic [4:0]  t_rd_i = 0;
  logic        t_req_o, t_we_o;
  logic [31:0] t_maddr_o, t_mwdata_o;
  logic [3:0]  t_be_o;
  logic        t_gnt_i = 0, t_rvalid_i = 0, t_err_i = 0;
  logic [31:0] t_rdata_i = 0;
  logic        t_reg_we_o, t_exc_valid_o, t_busy_o;
  logic [4:0]  t_waddr_o;
  logic [31:0] t_wdata_o, t_exc_addr_o;
  logic [1:0]  t_exc_cause_o;

  prirv32_lsu dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .exu_valid_i(exu_valid_i), .exu_ready_o(exu_ready_o), .exu_op_i(exu_op_i),
    .exu_addr_i(exu_addr_i), .exu_wdata_i(exu_wdata_i), .exu_rd_i(exu_rd_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o), .exc_addr_o(exc_addr_o),
    .busy_o(busy_o)
  );

  prirv32_lsu #(.TIMEOUT_CYCLES(4)) u_to (
    .clk_i(clk_i), .rst_n(rst_n),
    .exu_valid_i(t_valid_i), .exu_ready_o(t_ready_o), .exu_op_i(t_op_i),
    .exu_addr_i(t_addr_i), .exu_wdata_i(t_wdata_i), .exu_rd_i(t_rd_i),
    .mem_req_o(t_req_o), .mem_we_o(t_we_o), .mem_addr_o(t_maddr_o),
    .mem_be_o(t_be_o), .mem_wdata_o(t_mwdata_o), .mem_gnt_i(t_gnt_i),
    .mem_rvalid_i(t_rvalid_i), .mem_rdata_i(t_rdata_i), .mem_err_i(t_err_i),
    .reg_we_o(t_reg_we_o), .reg_waddr_o(t_waddr_o), .reg_wdata_o(t_wdata_o),
    .exc_valid_o(t_exc_valid_o), .exc_cause_o(t_exc_cause_o), .exc_addr_o(t_exc_addr_o),
    .busy_o(t_busy_o)
  );

  typedef struct { int cyc; logic [4:0] a; logic [31:0] d; } wr_t;
  typedef struct { int cyc; logic [1:0] cause; logic [31:0] a; } ex_t;
  typedef struct { logic we; logic [31:0] a; logic [3:0] be; logic [31:0] d; int hold; } mr_t;

  wr_t wr_q[$];
  ex_t ex_q[$];
  ex_t tex_q[$];
  mr_t mr_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // bus responder configuration
  int   bus_gnt_dly = 0;
  int   bus_resp_dly = 0;
  logic bus_err = 0;
  logic bus_drop = 0;
  logic [31:0] bus_rdata = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event, value %h (cycle %0d)", name, act, cyc);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, output int t, output int waited);
    waited = 0;
    @(negedge clk_i);
    while (!exu_ready_o && waited < 100) begin
      @(negedge clk_i);
      waited++;
    end
    if (!exu_ready_o) unexpected("issue_ready_timeout", 32'(waited));
    exu_valid_i = 1'b1;
    exu_op_i    = op;
    exu_addr_i  = addr;
    exu_wdata_i = wd;
    exu_rd_i    = rd;
    t = cyc;
    @(posedge clk_i);
    #1 exu_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!exu_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!exu_ready_o) unexpected(name, 32'(n));
  endtask

  task automatic check_zero(input string name);
    chk({name, "_reg_we"}, 32'(reg_we_o), 0);
    chk({name, "_reg_waddr"}, 32'(reg_waddr_o), 0);
    chk({name, "_reg_wdata"}, reg_wdata_o, 0);
    chk({name, "_exc"}, {29'd0, exc_valid_o, exc_cause_o}, 0);
    chk({name, "_exc_addr"}, exc_addr_o, 0);
    chk({name, "_mem_ctl"}, {26'd0, mem_req_o, mem_we_o, mem_be_o}, 0);
    chk({name, "_mem_addr"}, mem_addr_o, 0);
    chk({name, "_mem_wdata"}, mem_wdata_o, 0);
    chk({name, "_ready_busy"}, {30'd0, exu_ready_o, busy_o}, 32'h2);
  endtask

  // bus responder: grant after bus_gnt_dly waits, rvalid bus_resp_dly cycles after grant
  initial begin
    int req_wait;
    int resp_wait;
    req_wait = 0;
    resp_wait = -1;
    forever begin
      @(negedge clk_i);
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = 0;
      if (!rst_n) begin
        req_wait = 0;
        resp_wait = -1;
      end else begin
        if (resp_wait == 0) begin
          mem_rvalid_i = 1; mem_err_i = bus_err; mem_rdata_i = bus_rdata;
          resp_wait = -1;
        end else if (resp_wait > 0) begin
          resp_wait--;
        end
        if (mem_req_o) begin
          if (req_wait >= bus_gnt_dly) begin
            mem_gnt_i = 1;
            req_wait = 0;
            if (!bus_drop) resp_wait = bus_resp_dly;
          end else begin
            req_wait++;
          end
        end else begin
          req_wait = 0;
        end
      end
    end
  end

  // monitor: pops expectations whenever the DUTs present an output
  initial begin
    wr_t e;
    ex_t x;
    mr_t cur;
    logic [68:0] snap;
    bit in_req;
    int req_cycles;
    in_req = 0;
    req_cycles = 0;
    forever begin
      @(negedge clk_i);
      if (rst_n) begin
        if (reg_we_o) begin
          if (wr_q.size() == 0) unexpected("reg_write", {27'd0, reg_waddr_o});
          else begin
            e = wr_q.pop_front();
            chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            chk("wr_addr", 32'(reg_waddr_o), 32'(e.a));
            chk("wr_data", reg_wdata_o, e.d);
          end
        end
        if (exc_valid_o) begin
          if (ex_q.size() == 0) unexpected("exception", exc_addr_o);
          else begin
            x = ex_q.pop_front();
            chk("exc_cycle", 32'(cyc), 32'(x.cyc));
            chk("exc_cause", 32'(exc_cause_o), 32'(x.cause));
            chk("exc_addr", exc_addr_o, x.a);
          end
        end
        if (mem_req_o) begin
          if (!in_req) begin
            in_req = 1;
            req_cycles = 1;
            snap = {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o};
            if (mr_q.size() == 0) begin
              unexpected("mem_req", mem_addr_o);
              cur = '{we: 0, a: 0, be: 0, d: 0, hold: -1};
            end else begin
              cur = mr_q.pop_front();
              chk("req_addr", mem_addr_o, cur.a);
              chk("req_we", 32'(mem_we_o), 32'(cur.we));
              chk("req_be", 32'(mem_be_o), 32'(cur.be));
              if (cur.we) chk("req_wdata", mem_wdata_o, cur.d);
            end
          end else begin
            req_cycles++;
            chk("req_stable", 32'(snap == {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}), 1);
          end
        end else if (in_req) begin
          in_req = 0;
          if (cur.hold > 0) chk("req_hold", 32'(req_cycles), 32'(cur.hold));
        end
        if (t_reg_we_o) unexpected("to_reg_write", {27'd0, t_waddr_o});
        if (t_exc_valid_o) begin
          if (tex_q.size() == 0) unexpected("to_exception", t_exc_addr_o);
          else begin
            x = tex_q.pop_front();
            chk("to_exc_cycle", 32'(cyc), 32'(x.cyc));
            chk("to_exc_cause", 32'(t_exc_cause_o), 32'(x.cause));
            chk("to_exc_addr", t_exc_addr_o, x.a);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, w, tt;
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    check_zero("reset");

    // ALU-WB back-to-back
    issue(4'd0, 32'h11, 0, 5'd5, t, w);
    wr_q.push_back('{cyc: t + 1, a: 5'd5, d: 32'h11});
    issue(4'd0, 32'h22, 0, 5'd6, t2, w);
    wr_q.push_back('{cyc: t2 + 1, a: 5'd6, d: 32'h22});
    chk("alu_b2b_cycle", 32'(t2 - t), 1);
    chk("alu_b2b_ready_wait", 32'(w), 0);

    // LB / LBU at 0x1003, zero-wait bus, minimum latency
    bus_rdata = 32'h80FF_FF00;
    issue(4'd1, 32'h1003, 0, 5'd3, t, w);
    mr_q.push_back('{we: 0, a: 32'h1000, be: 4'hF, d: 0, hold: 1});
    wr_q.push_back('{cyc: t + 3, a: 5'd3, d: 32'hFFFF_FF80});
    issue(4'd4, 32'h1003, 0, 5'd3, t2, w);
    mr_q.push_back('{we: 0, a: 32'h1000, be: 4'hF, d: 0, hold: 1});
    wr_q.push_back('{cyc: t2 + 3, a: 5'd3, d: 32'h0000_0080});
    chk("load_min_latency", 32'(t2 - t), 4);
    wait_idle("idle_lbu");

    // LH / LHU upper half, LW aligned
    bus_rdata = 32'h8001_7F00;
    issue(4'd2, 32'h1002, 0, 5'd8, t, w);
    mr_q.push_back('{we: 0, a: 32'h1000, be: 4'hF, d: 0, hold: 1});
    wr_q.push_back('{cyc: t + 3, a: 5'd8, d: 32'hFFFF_8001});
    issue(4'd5, 32'h1002, 0, 5'd8, t, w);
    mr_q.push_back('{we: 0, a: 32'h1000, be: 4'hF, d: 0, hold: 1});
    wr_q.push_back('{cyc: t + 3, a: 5'd8, d: 32'h0000_8001});
    wait_idle("idle_lhu");
    bus_rdata = 32'hDEAD_BEEF;
    issue(4'd3, 32'h1004, 0, 5'd9, t, w);
    mr_q.push_back('{we: 0, a: 32'h1004, be: 4'hF, d: 0, hold: 1});
    wr_q.push_back('{cyc: t + 3, a: 5'd9, d: 32'hDEAD_BEEF});
    wait_idle("idle_lw");

    // SH with grant delayed 3 cycles, then SB
    bus_gnt_dly = 3;
    issue(4'd9, 32'h2002, 32'hABCD_1234, 5'd1, t, w);
    mr_q.push_back('{we: 1, a: 32'h2000, be: 4'b1100, d: 32'h1234_1234, hold: 4});
    wait_idle("idle_sh");
    bus_gnt_dly = 0;
    issue(4'd8, 32'h1001, 32'h0000_00AB, 5'd1, t, w);
    mr_q.push_back('{we: 1, a: 32'h1000, be: 4'b0010, d: 32'hABAB_ABAB, hold: 1});
    wait_idle("idle_sb");

    // misaligned LW and SH, then a no-op code
    issue(4'd3, 32'h3001, 0, 5'd4, t, w);
    ex_q.push_back('{cyc: t + 1, cause: 2'd0, a: 32'h3001});
    issue(4'd9, 32'h2001, 32'h5555, 5'd4, t, w);
    ex_q.push_back('{cyc: t + 1, cause: 2'd1, a: 32'h2001});
    issue(4'd6, 32'h7000, 32'h1, 5'd7, t, w);

    // SW with bus error
    bus_err = 1'b1;
    issue(4'd10, 32'h5000, 32'h1122_3344, 5'd2, t, w);
    mr_q.push_back('{we: 1, a: 32'h5000, be: 4'hF, d: 32'h1122_3344, hold: 1});
    ex_q.push_back('{cyc: t + 3, cause: 2'd3, a: 32'h5000});
    wait_idle("idle_sw_err");
    bus_err = 1'b0;

    // timeout on the TIMEOUT_CYCLES=4 instance; late rvalid must be ignored
    @(negedge clk_i);
    t_op_i = 4'd3; t_addr_i = 32'h4000; t_rd_i = 5'd7; t_valid_i = 1'b1;
    tt = cyc;
    @(posedge clk_i);
    #1 t_valid_i = 1'b0;
    @(negedge clk_i);
    chk("to_req", 32'(t_req_o), 1);
    t_gnt_i = 1'b1;
    @(negedge clk_i);
    t_gnt_i = 1'b0;
    tex_q.push_back('{cyc: tt + 5, cause: 2'd2, a: 32'h4000});
    repeat (2) @(negedge clk_i);
    chk("to_busy_before_limit", 32'(t_busy_o), 1);
    repeat (2) @(negedge clk_i);
    t_rvalid_i = 1'b1; t_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    t_rvalid_i = 1'b0;
    chk("to_idle_after_late_rvalid", {30'd0, t_ready_o, t_busy_o}, 32'h2);

    // LW with rd=0: bus access but no register write
    issue(4'd3, 32'h6000, 0, 5'd0, t, w);
    mr_q.push_back('{we: 0, a: 32'h6000, be: 4'hF, d: 0, hold: 1});
    wait_idle("idle_lw_rd0");

    // reset pulsed while in RESP abandons the load
    bus_drop = 1'b1;
    issue(4'd3, 32'h6004, 0, 5'd9, t, w);
    mr_q.push_back('{we: 0, a: 32'h6004, be: 4'hF, d: 0, hold: 1});
    @(posedge clk_i);
    #2 chk("resp_busy_before_reset", 32'(busy_o), 1);
    rst_n = 1'b0;
    #1 chk("async_reset_clears", {29'd0, exu_ready_o, busy_o, reg_we_o}, 32'h4);
    chk("async_reset_addr", mem_addr_o, 0);
    @(posedge clk_i);
    #2 rst_n = 1'b1;
    bus_drop = 1'b0;
    @(negedge clk_i);
    check_zero("post_reset");

    issue(4'd0, 32'h55, 0, 5'd10, t, w);
    wr_q.push_back('{cyc: t + 1, a: 5'd10, d: 32'h55});

    repeat (6) @(negedge clk_i);
    chk("wr_q_drained", 32'(wr_q.size()), 0);
    chk("ex_q_drained", 32'(ex_q.size()), 0);
    chk("mr_q_drained", 32'(mr_q.size()), 0);
    chk("tex_q_drained", 32'(tex_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
